// File: rtl/byte_uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop serializer.
// Defining BYTE_UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module byte_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_count
);
    localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [7:0]    BIT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    DEPTH_W  = 5'(FIFO_DEPTH);

`ifdef BYTE_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_e;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    state_e        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          push_s, pop_s, bit_done_s;

    assign in_ready   = (count_q < DEPTH_W) && !rst;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // Serializer next state: the timer restarts whenever the line value changes meaning.
    always_comb begin
        push_s     = in_valid && in_ready;
        bit_done_s = (timer_q == BIT_LAST);
        pop_s      = 1'b0;
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: begin
                timer_d = 8'd0;
                if (count_q != 5'd0) begin
                    pop_s   = 1'b1;
                    byte_d  = mem_q[rd_ptr_q];
                    state_d = START;
                    tx_d    = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            START: begin
                if (bit_done_s) begin
                    state_d = DATA;
                    timer_d = 8'd0;
                    idx_d   = 3'd0;
                    tx_d    = byte_q[0];
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    timer_d = 8'd0;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef BYTE_UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = even_parity(byte_q);
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = byte_q[3'(idx_q + 3'd1)];
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
`ifdef BYTE_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done_s) begin
                    state_d = STOP;
                    timer_d = 8'd0;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
`endif
            STOP: begin
                if (bit_done_s) begin
                    timer_d = 8'd0;
                    // Chain straight into the next start bit so queued bytes leave without a gap.
                    if (count_q != 5'd0) begin
                        pop_s   = 1'b1;
                        byte_d  = mem_q[rd_ptr_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 8'd0;
                idx_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            timer_q  <= 8'd0;
            idx_q    <= 3'd0;
            byte_q   <= 8'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage; push is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end
endmodule

// File: tb/tb_byte_uart_tx.sv
// Directed bench for byte_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4); inputs change and outputs
// are sampled on the falling edge. Parity scenarios build only with BYTE_UART_TX_PARITY_EN.
module tb_byte_uart_tx;
    localparam int CPB = 4;
`ifdef BYTE_UART_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    int vectors    = 0;
    int miscompares = 0;

    byte_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level c cycles after the start-bit edge of a frame carrying b.
    function automatic logic exp_tx(input logic [7:0] b, input int c);
        if (c < CPB) return 1'b0;
        else if (c < 9 * CPB) return b[(c - CPB) / CPB];
`ifdef BYTE_UART_TX_PARITY_EN
        else if (c < 10 * CPB) return ^b;
`endif
        else return 1'b1;
    endfunction

    // Checks one whole frame starting at the sample right after its start edge.
    task automatic check_frame(input logic [7:0] b);
        for (int c = 0; c < FRAME; c++) begin
            check($sformatf("frame%02h_tx_c%0d", b, c), tx, exp_tx(b, c));
            check($sformatf("frame%02h_busy_c%0d", b, c), busy, 1'b1);
            tick();
        end
    endtask

    task automatic send_one(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        check("accept_count", fifo_count, 5'd1);
        check("accept_tx_idle", tx, 1'b1);
        tick();
        check("pop_count", fifo_count, 5'd0);
        check_frame(b);
        check("end_busy", busy, 1'b0);
        check("end_tx", tx, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        check("reset_state", {tx, busy, in_ready, fifo_count}, 8'b1000_0000);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle_c%0d", i), {tx, busy, in_ready, fifo_count}, 8'b1010_0000);
        end

        // Single 0xA5 frame: start, 1,0,1,0,0,1,0,1, stop, then idle.
        send_one(8'hA5);

        // Five back-to-back writes fill the FIFO while the first byte is already on the line.
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        check("b2b_e0_count", fifo_count, 5'd1);
        in_data = 8'h02;
        tick();
        check("b2b_e1_count", fifo_count, 5'd1);
        check("b2b_e1_tx", tx, 1'b0);
        in_data = 8'h03;
        tick();
        check("b2b_e2_count", fifo_count, 5'd2);
        in_data = 8'h04;
        tick();
        check("b2b_e3_count", fifo_count, 5'd3);
        in_data = 8'h05;
        tick();
        check("b2b_full_count", fifo_count, 5'd4);
        check("b2b_full_ready", in_ready, 1'b0);
        check("b2b_c3_tx", tx, 1'b0);
        in_data = 8'h06;
        for (int c = 4; c < FRAME; c++) begin
            tick();
            check($sformatf("full_tx_c%0d", c), tx, exp_tx(8'h01, c));
            check($sformatf("full_count_c%0d", c), fifo_count, 5'd4);
            check($sformatf("full_ready_c%0d", c), in_ready, 1'b0);
        end
        // Stop completes with a write attempt pending: pop only.
        tick();
        check("stop_pop_count", fifo_count, 5'd3);
        check("stop_pop_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        check_frame(8'h02);
        check_frame(8'h03);
        check_frame(8'h04);
        check_frame(8'h05);
        check("drain_busy", busy, 1'b0);
        check("drain_tx", tx, 1'b1);
        check("drain_count", fifo_count, 5'd0);

        // Reset during data bit 3 of 0x5A with two bytes queued.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        check("abort_queued", fifo_count, 5'd2);
        for (int i = 0; i < 7; i++) tick();
        check("abort_bit1_tx", tx, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("abort_bit2_tx", tx, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("abort_bit3_tx", tx, 1'b1);
        check("abort_bit3_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("abort_state", {tx, busy, in_ready, fifo_count}, 8'b1000_0000);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check($sformatf("post_abort_c%0d", i), {tx, busy, in_ready, fifo_count}, 8'b1010_0000);
        end

`ifdef BYTE_UART_TX_PARITY_EN
        send_one(8'h07);
        send_one(8'hA5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/byte_uart_tx.md
BYTE_UART_TX -- requirements
Module: byte_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held; legal range 1..255.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries buffered ahead of the serializer; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  upstream byte present on in_data (fed from the delay-line data_out).
REQ-006 in_data  input  8  byte to transmit.
REQ-007 in_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 tx  output  1  registered serial line, idle high.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 fifo_count  output  5  number of bytes currently held in the FIFO.

Function
REQ-011 A byte SHALL be written into the FIFO on a rising edge where in_valid=1 and in_ready=1; in_data is otherwise ignored.
REQ-012 in_ready SHALL equal (fifo_count < FIFO_DEPTH) and rst=0; when full, in_valid is ignored with no write and no error.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-014 IDLE with fifo_count>0 at an edge: pop head byte, enter START, tx<=0 on that same edge.
REQ-015 Latency: a byte accepted into an empty FIFO while IDLE at edge E0 SHALL drive tx low after edge E1.
REQ-016 Each state SHALL hold tx for exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads on every state or bit change.
REQ-017 DATA SHALL send in_data bits LSB first, 8 bits, using a 3-bit index that wraps 7->0 on exit.
REQ-018 STOP SHALL drive tx=1; on completion, if fifo_count>0, pop and enter START on the same edge (no idle gap); else enter IDLE.
REQ-019 A simultaneous FIFO write and pop on the same edge SHALL leave fifo_count unchanged and preserve byte order.
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH; bytes leave strictly in arrival order.
REQ-021 busy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-022 Frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.

Reset
REQ-023 On rst=1 at an edge: state<=IDLE, tx<=1, FIFO pointers and fifo_count<=0, bit-timer and bit index<=0.
REQ-024 Reset mid-frame SHALL abort the frame: tx=1 and busy=0 from the next edge, and buffered bytes are discarded.
REQ-025 in_ready SHALL be 0 while rst=1 and 1 from the first cycle after rst deasserts.

Configuration
REQ-026 Macro BYTE_UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, tx = even parity bit (XOR of the 8 data bits).
REQ-027 Macro undefined: no PARITY state or parity logic; DATA proceeds directly to STOP.

Verification
REQ-028 Reset, then idle 20 cycles -> tx=1, busy=0, in_ready=1, fifo_count=0 throughout.
REQ-029 CLKS_PER_BIT=4, no parity, write 0xA5 once -> tx low 1 cycle after accept, then bits 1,0,1,0,0,1,0,1 of 4 cycles each, stop high 4 cycles, busy low at cycle 40.
REQ-030 Write 0x01,0x02,0x03,0x04,0x05 back-to-back -> first 5 accepted (one popped immediately), then in_ready=0 once fifo_count=4; frames emitted in order with no idle cycle between stops and starts.
REQ-031 FIFO full, write attempt on the same edge STOP completes -> no write that edge, count drops to 3, in_ready=1 next cycle.
REQ-032 rst pulse during DATA bit 3 of 0x5A with 2 bytes queued -> next edge tx=1, busy=0, fifo_count=0; no further frames emitted.
REQ-033 BYTE_UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame 44 cycles; send 0xA5 -> parity bit 0.
